// File: rtl/inv_mix_col_state_if.sv
// Bus bundle for inv_mix_col_state: upstream state-memory read port,
// sequencing status, and the Add-Round-Key result read-out port.
interface inv_mix_col_state_if;
  logic       start;
  logic [7:0] data_in;
  logic [3:0] data_addr;
  logic       flag;
  logic       DONE;
  logic       ADD_ROUND_start;
  logic [3:0] ADD_ROUND_addr;
  logic [7:0] out_mem;

  // Engine side
  modport slave (
    input  start, data_in, ADD_ROUND_start, ADD_ROUND_addr,
    output data_addr, flag, DONE, out_mem
  );

  // Upstream memory / controller side
  modport master (
    output start, data_in, ADD_ROUND_start, ADD_ROUND_addr,
    input  data_addr, flag, DONE, out_mem
  );
endinterface

// File: rtl/inv_mix_col_state.sv
// Byte-serial AES InvMixColumns engine. Walks a 6-bit {c,r,k} sequence,
// multiplies each fetched byte by the inverse coefficient and accumulates
// every output byte into a 16-byte result memory read back by Add-Round-Key.
// Optional build macro: INV_MIX_COL_RESTART_EN (start while busy restarts).
//
//   state | meaning
//   IDLE  | waiting for start
//   RUN   | issuing the 64 upstream reads
//   DRAIN | last product accumulates and is written
//   FIN   | DONE pulse; a new start is already accepted here
module inv_mix_col_state (
  input  logic                   clk,
  input  logic                   rst,
  inv_mix_col_state_if.slave     bus
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        restart;
  logic        vld_q;
  logic [1:0]  c_p_q, r_p_q, k_p_q;
  logic [7:0]  acc_q, acc_d;
  logic [7:0]  mem_q [16];
  logic [7:0]  out_q;
  logic [7:0]  x1, x2, x4, x8, prod;
  logic [1:0]  coef_sel;
  logic        wr_en;
  logic [3:0]  rd_addr;

  function automatic logic [7:0] xtime(input logic [7:0] v);
    xtime = {v[6:0], 1'b0} ^ (v[7] ? 8'h1B : 8'h00);
  endfunction

`ifdef INV_MIX_COL_RESTART_EN
  assign restart = bus.start && (state_q == RUN || state_q == DRAIN);
`else
  assign restart = 1'b0;
`endif

  // State and sequence counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 6'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and counter logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          cnt_d   = 6'd0;
        end
      end
      RUN: begin
        if (restart)              cnt_d   = 6'd0;
        else if (cnt_q == 6'd63)  state_d = DRAIN;
        else                      cnt_d   = cnt_q + 6'd1;
      end
      DRAIN: begin
        if (restart) begin
          state_d = RUN;
          cnt_d   = 6'd0;
        end else begin
          state_d = FIN;
        end
      end
      FIN: begin
        if (bus.start) begin
          state_d = RUN;
          cnt_d   = 6'd0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.flag      = (state_q == RUN);
  assign bus.DONE      = (state_q == FIN);
  assign bus.data_addr = bus.flag ? {cnt_q[5:4], cnt_q[1:0]} : 4'd0;

  // Delay {c,r,k} one cycle so they line up with data_in; a restart kills
  // the fetch issued in the restarting cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= 1'b0;
      c_p_q <= 2'd0;
      r_p_q <= 2'd0;
      k_p_q <= 2'd0;
    end else begin
      vld_q <= (state_q == RUN) && !restart;
      c_p_q <= cnt_q[5:4];
      r_p_q <= cnt_q[3:2];
      k_p_q <= cnt_q[1:0];
    end
  end

  // GF(2^8) product by coef[(k-r) mod 4], coef = {0E,0B,0D,09}
  always_comb begin
    x1       = bus.data_in;
    x2       = xtime(x1);
    x4       = xtime(x2);
    x8       = xtime(x4);
    coef_sel = k_p_q - r_p_q;
    case (coef_sel)
      2'd0:    prod = x8 ^ x4 ^ x2;
      2'd1:    prod = x8 ^ x2 ^ x1;
      2'd2:    prod = x8 ^ x4 ^ x1;
      default: prod = x8 ^ x1;
    endcase
    acc_d = ((k_p_q == 2'd0) ? 8'h00 : acc_q) ^ prod;
    wr_en = vld_q && (k_p_q == 2'd3) && !restart;
  end

  // Column accumulator
  always_ff @(posedge clk) begin
    if (rst || restart) acc_q <= 8'h00;
    else if (vld_q)     acc_q <= acc_d;
  end

  // Result memory write; finished byte lands at 4*c + r
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) mem_q[i] <= 8'h00;
    end else if (wr_en) begin
      mem_q[{c_p_q, r_p_q}] <= acc_d;
    end
  end

  assign rd_addr = bus.ADD_ROUND_start ? bus.ADD_ROUND_addr : {c_p_q, r_p_q};

  // Registered read port, independent of the write side
  always_ff @(posedge clk) begin
    if (rst) out_q <= 8'h00;
    else     out_q <= mem_q[rd_addr];
  end

  assign bus.out_mem = out_q;

endmodule

// File: doc/inv_mix_col_state.md
# inv_mix_col_state

Byte-serial InvMixColumns engine for the AES-128 decryption datapath. It reads the 16-byte state one byte per cycle from the preceding stage's state memory and multiplies each byte by the inverse coefficients {0E,0B,0D,09} over GF(2^8). It accumulates each output byte by XOR and writes the result into an internal 16-byte result memory. The Add-Round-Key stage later reads that memory through a muxed address port. It is the decryption counterpart of the MixColumns state block and uses the same byte indexing and read-out handshake.

## Interface
Parameters:
- none

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  one-cycle pulse; begins a transform when idle
- data_in  in  8  state byte from upstream memory; valid the cycle after data_addr
- data_addr  out  4  upstream state-memory read address
- flag  out  1  high while read addresses are being issued
- DONE  out  1  one-cycle pulse; all 16 result bytes written
- ADD_ROUND_start  in  1  when high, ADD_ROUND_addr drives the result-memory read port
- ADD_ROUND_addr  in  4  result-memory read address
- out_mem  out  8  registered result-memory read data

## Operation
- Byte index is 4*c + r, column-major (c = column, r = row), as elsewhere in the datapath.
- Output byte: s'[r,c] = XOR over k=0..3 of coef[(k−r) mod 4] · s[k,c], with coef = {0E,0B,0D,09}.
- GF multiplication is combinational: a chain of xtime steps with polynomial 0x11B.
- 6-bit sequence counter {c,r,k} runs 0..63. k is innermost, then r, then c.
  - Each count issues data_addr = 4*c + k.
- States:
  - IDLE: start → RUN, counter = 0.
  - RUN: the counter increments every cycle; at 63 → DRAIN.
  - DRAIN: the last product accumulates and is written → FIN.
  - FIN: DONE = 1 → IDLE.
- Pipeline: {r,k,c} are delayed one cycle alongside data_in.
  - acc_next = (k_d==0 ? 0 : acc) ^ product.
  - When k_d==3, acc_next is written to result memory at 4*c_d + r_d on the same edge.
- Read port: the address is ADD_ROUND_start ? ADD_ROUND_addr : 4*c_d + r_d. out_mem is registered.
  - Reads and writes are independent; a read during RUN is legal and returns the current contents.
- start while busy: ignored, unless the macro under Configuration is defined.
- Idle outputs: data_addr = 0, flag = 0.

## Timing
- Cycle S is the cycle in which start=1 is sampled in IDLE.
- data_addr issues reads 0..63 in cycles S+1..S+64. flag is high in exactly those cycles.
- First result write (byte 0): end of cycle S+5. Last write (byte 15): end of cycle S+65.
- DONE is high only in cycle S+66. The block accepts a new start in cycle S+66.
- Readback: address applied in cycle t → out_mem valid in cycle t+1.
- Reset values: flag 0, DONE 0, data_addr 0, out_mem 00, acc 00, all 16 result bytes 00, state IDLE.
- rst asserted mid-transform: the next cycle is IDLE with all outputs at reset values. No DONE is produced.
- rst and start in the same cycle: rst wins.

## Configuration
- INV_MIX_COL_RESTART_EN
  - Defined: start sampled in RUN or DRAIN aborts the transform.
    - The counter and acc clear, and reads restart at address 0 in the next cycle.
    - Result bytes already written are kept until overwritten.
    - DONE fires 66 cycles after the restarting start.
  - Undefined: start outside IDLE is ignored.

## Test plan
- Upstream memory holds, addresses 0..15: 8e 4d a1 bc 9f dc 58 9d 01 01 01 01 d5 d5 d7 d6. Pulse start, then read back 0..15 → db 13 53 45 f2 0a 22 5c 01 01 01 01 d4 d4 d4 d5.
  - DONE is high only in cycle S+66.
- Same run, check sequencing → data_addr is 0,1,2,3 repeated 4 times, then 4..7 ×4, then 8..11 ×4, then 12..15 ×4.
  - flag is high for exactly 64 consecutive cycles starting at S+1.
- All-c6 state → all 16 results c6. All-00 state → all 00.
- Second start at S+20:
  - Without the macro → single DONE at S+66, correct results.
  - With the macro → DONE only at S+86, correct results.
- rst asserted at S+30 → from S+31: flag 0, DONE never asserts, data_addr 0. Readback of every address returns 00.
- Hold ADD_ROUND_start=1 and sweep ADD_ROUND_addr during RUN → out_mem follows the result memory with 1-cycle latency. The final results are still correct.
